// File: rtl/led_bar_controller.sv
// LED bar fill controller: debounced-edge buttons step a 0..16 fill level
// manually, or an auto mode sweeps it up and down with a dwell at each end.
module led_bar_controller #(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mode,
    output logic [4:0] current_count,
    output logic       auto_active,
    output logic       at_max,
    output logic       at_min
);

    localparam int unsigned CW = 5;
    localparam int unsigned HW = 8;
    localparam int unsigned NB = 3;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0] COUNT_MAX  = CW'(16);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS);

    typedef enum logic [1:0] {
        MANUAL    = 2'd0,
        AUTO_UP   = 2'd1,
        AUTO_DOWN = 2'd2,
        HOLD      = 2'd3
    } state_t;

    // Button front end: bit 0 = up, bit 1 = down, bit 2 = mode.
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] prev_q;
    logic [NB-1:0] arm_q;
    logic [1:0]    live_q;
    logic [NB-1:0] btn_ev;
    logic          up_ev;
    logic          down_ev;
    logic          mode_ev;

    assign btn_raw = {btn_mode, btn_down, btn_up};

    // Synchronize buttons; a button may only fire once it has been seen low
    // after reset, so a button held through reset release stays silent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            arm_q   <= '0;
            live_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            live_q  <= {live_q[0], 1'b1};
            arm_q   <= arm_q | ({NB{live_q[1]}} & ~sync2_q);
        end
    end

    assign btn_ev  = sync2_q & ~prev_q & arm_q;
    assign up_ev   = btn_ev[0];
    assign down_ev = btn_ev[1];
    assign mode_ev = btn_ev[2];

    // Core state.
    state_t        state_q,    state_d;
    logic [CW-1:0] count_q,    count_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          hold_dir_q, hold_dir_d;
    logic [PW-1:0] presc_q,    presc_d;
    logic          auto_d;
    logic          at_max_d;
    logic          at_min_d;
    logic          tick;

    assign tick = (presc_q == PRESC_LAST);

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= MANUAL;
            count_q       <= '0;
            hold_cnt_q    <= '0;
            hold_dir_q    <= 1'b0;
            presc_q       <= '0;
            auto_active   <= 1'b0;
            at_max        <= 1'b0;
            at_min        <= 1'b1;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            hold_cnt_q    <= hold_cnt_d;
            hold_dir_q    <= hold_dir_d;
            presc_q       <= presc_d;
            auto_active   <= auto_d;
            at_max        <= at_max_d;
            at_min        <= at_min_d;
        end
    end

    assign current_count = count_q;

    // Next-state logic; a mode event always beats a coincident tick.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hold_cnt_d = hold_cnt_q;
        hold_dir_d = hold_dir_q;
        presc_d    = tick ? '0 : PW'(presc_q + PW'(1));

        case (state_q)
            MANUAL: begin
                if (mode_ev) begin
                    state_d = (count_q < COUNT_MAX) ? AUTO_UP : AUTO_DOWN;
                    presc_d = '0;
                end else if (up_ev && !down_ev) begin
                    if (count_q < COUNT_MAX) begin
                        count_d = CW'(count_q + COUNT_ONE);
                    end
                end else if (down_ev && !up_ev) begin
                    if (count_q != '0) begin
                        count_d = CW'(count_q - COUNT_ONE);
                    end
                end
            end

            AUTO_UP: begin
                if (mode_ev) begin
                    state_d = MANUAL;
                end else if (tick) begin
                    if (count_q >= CW'(COUNT_MAX - COUNT_ONE)) begin
                        count_d    = COUNT_MAX;
                        state_d    = HOLD;
                        hold_dir_d = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        count_d = CW'(count_q + COUNT_ONE);
                    end
                end
            end

            AUTO_DOWN: begin
                if (mode_ev) begin
                    state_d = MANUAL;
                end else if (tick) begin
                    if (count_q <= COUNT_ONE) begin
                        count_d    = '0;
                        state_d    = HOLD;
                        hold_dir_d = 1'b0;
                        hold_cnt_d = '0;
                    end else begin
                        count_d = CW'(count_q - COUNT_ONE);
                    end
                end
            end

            HOLD: begin
                if (mode_ev) begin
                    state_d = MANUAL;
                end else if (tick) begin
                    hold_cnt_d = HW'(hold_cnt_q + HW'(1));
                    if (hold_cnt_d == HOLD_LAST) begin
                        state_d = hold_dir_q ? AUTO_DOWN : AUTO_UP;
                    end
                end
            end

            default: begin
                state_d = MANUAL;
            end
        endcase

        auto_d   = (state_d != MANUAL);
        at_max_d = (count_d == COUNT_MAX);
        at_min_d = (count_d == '0);
    end

endmodule

// File: tb/tb_led_bar_controller.sv
// Directed self-checking bench for led_bar_controller (TICK_DIV=4, HOLD_TICKS=2).
module tb_led_bar_controller;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_mode;
    logic [4:0] current_count;
    logic       auto_active;
    logic       at_max;
    logic       at_min;

    int n_vec;
    int n_err;

    led_bar_controller #(
        .TICK_DIV   (4),
        .HOLD_TICKS (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_mode      (btn_mode),
        .current_count (current_count),
        .auto_active   (auto_active),
        .at_max        (at_max),
        .at_min        (at_min)
    );

    // 10 ns clock; inputs driven and outputs sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold the given buttons for three edges, check the count, release and settle.
    task automatic press(input logic u, input logic d, input logic m,
                         input logic [4:0] exp, input string tag);
        btn_up   = u;
        btn_down = d;
        btn_mode = m;
        repeat (3) @(negedge clk);
        check(tag, 32'(current_count), 32'(exp));
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_mode = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Expected count k edges after auto entry at 14 (mode event edge = k 0).
    function automatic int exp_auto(input int k);
        if (k < 4)        return 14;
        else if (k < 8)   return 15;
        else if (k < 20)  return 16;
        else if (k < 80)  return 16 - (k - 16) / 4;
        else if (k < 92)  return 0;
        else if (k < 152) return 1 + (k - 92) / 4;
        else if (k < 164) return 16;
        else              return 16 - (k - 160) / 4;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_mode = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_count", 32'(current_count), 32'd0);
        check("rst_auto",  32'(auto_active),   32'd0);
        check("rst_min",   32'(at_min),        32'd1);
        check("rst_max",   32'(at_max),        32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // First press: change lands on edge 3, held button fires once.
        btn_up = 1'b1;
        repeat (2) @(negedge clk);
        check("lat_edge2", 32'(current_count), 32'd0);
        @(negedge clk);
        check("lat_edge3", 32'(current_count), 32'd1);
        repeat (5) @(negedge clk);
        check("held_once", 32'(current_count), 32'd1);
        btn_up = 1'b0;
        repeat (3) @(negedge clk);

        // Up presses to saturation.
        for (int i = 2; i <= 17; i++) begin
            press(1'b1, 1'b0, 1'b0, 5'((i > 16) ? 16 : i), $sformatf("up_%0d", i));
            if (i == 16) check("at_max_16", 32'(at_max), 32'd1);
        end
        check("sat_max", 32'(at_max), 32'd1);

        // Down presses to zero, then one more.
        for (int i = 15; i >= -1; i--) begin
            press(1'b0, 1'b1, 1'b0, 5'((i < 0) ? 0 : i), $sformatf("down_%0d", i));
        end
        check("sat_min", 32'(at_min), 32'd1);
        check("sat_max0", 32'(at_max), 32'd0);

        // Simultaneous up/down at 5 is a no-op.
        for (int i = 1; i <= 5; i++) press(1'b1, 1'b0, 1'b0, 5'(i), "up_to5");
        press(1'b1, 1'b1, 1'b0, 5'd5, "both_5");

        // Sub-period pulse caught by one edge gives one increment 3 edges later.
        btn_up = 1'b1;
        #7;
        btn_up = 1'b0;
        @(negedge clk);
        check("pulse_e1", 32'(current_count), 32'd5);
        @(negedge clk);
        check("pulse_e2", 32'(current_count), 32'd5);
        @(negedge clk);
        check("pulse_e3", 32'(current_count), 32'd6);
        repeat (5) @(negedge clk);
        check("pulse_once", 32'(current_count), 32'd6);

        // Climb to 14 and start the auto sweep.
        for (int i = 7; i <= 14; i++) press(1'b1, 1'b0, 1'b0, 5'(i), "up_to14");
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        check("auto_entry", 32'(current_count), 32'd14);
        check("auto_on",    32'(auto_active),   32'd1);
        btn_mode = 1'b0;
        for (int k = 1; k <= 189; k++) begin
            @(negedge clk);
            check($sformatf("sweep_k%0d", k), 32'(current_count), 32'(exp_auto(k)));
            if (k == 8 || k == 150 || k == 188)
                check($sformatf("sweep_auto_k%0d", k), 32'(auto_active), 32'd1);
            if (k == 8)
                check("sweep_max", 32'(at_max), 32'd1);
            if (k == 80)
                check("sweep_min", 32'(at_min), 32'd1);
        end

        // Mode event on the tick edge in AUTO_DOWN at 9: back to manual, no step.
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        check("exit_count", 32'(current_count), 32'd9);
        check("exit_auto",  32'(auto_active),   32'd0);
        btn_mode = 1'b0;
        repeat (8) @(negedge clk);
        check("manual_stay", 32'(current_count), 32'd9);
        press(1'b1, 1'b0, 1'b0, 5'd10, "manual_up");
        press(1'b1, 1'b1, 1'b1, 5'd10, "ign_check_pre");
        check("mode_both_auto", 32'(auto_active), 32'd1);

        // Ride up to HOLD at 16 (entry was 3 edges into the press above).
        repeat (22) @(negedge clk);
        check("hold_count", 32'(current_count), 32'd16);
        check("hold_max",   32'(at_max),        32'd1);
        check("hold_auto",  32'(auto_active),   32'd1);

        // Reset in HOLD with btn_mode held through release.
        btn_mode = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        check("mid_rst_count", 32'(current_count), 32'd0);
        check("mid_rst_min",   32'(at_min),        32'd1);
        check("mid_rst_max",   32'(at_max),        32'd0);
        check("mid_rst_auto",  32'(auto_active),   32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("held_mode_%0d", i), 32'(auto_active), 32'd0);
        end
        btn_mode = 1'b0;
        repeat (4) @(negedge clk);
        press(1'b1, 1'b0, 1'b0, 5'd1, "post_rst_up");
        check("post_rst_auto", 32'(auto_active), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
